// File: rtl/base_endian_arb.sv
// Round-robin arbiter sharing one byte-reversal stage between `ways` requesters.
// Optional burst locking is compiled in with BASE_ENDIAN_ARB_LOCK_EN.
module base_endian_arb #(
  parameter int ways  = 2,
  parameter int bytes = 8,
  localparam int TW   = (ways > 1) ? $clog2(ways) : 1,
  localparam int DW   = 8 * bytes
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [0:ways-1]         i_v,
  output logic [0:ways-1]         o_r,
  input  logic [0:ways*DW-1]      i_d,
  input  logic [0:ways-1]         i_szl,
  input  logic [0:ways-1]         i_last,
  output logic                    o_v,
  input  logic                    i_r,
  output logic [0:DW-1]           o_d,
  output logic [0:TW-1]           o_tag,
  output logic                    o_last
);

  function automatic logic [0:DW-1] swap_bytes(input logic [0:DW-1] d);
    logic [0:DW-1] r;
    r = {DW{1'b0}};
    for (int k = 0; k < bytes; k++) begin
      r[8*k +: 8] = d[8*(bytes-1-k) +: 8];
    end
    return r;
  endfunction

  // ways need not be a power of two, so wrap explicitly
  function automatic logic [TW-1:0] ptr_after(input logic [TW-1:0] w);
    logic [TW-1:0] r;
    if (int'(w) >= ways - 32'sd1) begin
      r = {TW{1'b0}};
    end else begin
      r = TW'(int'(w) + 32'sd1);
    end
    return r;
  endfunction

  logic [0:ways-1] elig_s;
  logic            found_s;
  logic [TW-1:0]   win_s;
  logic [0:DW-1]   win_data_s;
  logic            win_szl_s;
  logic            win_last_s;
  logic            acc_en_s;
  logic            accept_s;
  logic            ptr_adv_s;

  logic [TW-1:0]   ptr_q;
  logic [TW-1:0]   ptr_d;
  logic            o_v_q;
  logic [0:DW-1]   dat_q;
  logic [0:DW-1]   dat_d;
  logic [TW-1:0]   tag_q;
  logic            last_q;

  assign acc_en_s = ~o_v_q | i_r;
  assign accept_s = acc_en_s & found_s;

  // Winner = eligible requester at the smallest upward distance from ptr
  always_comb begin
    int  dist_v;
    int  best_v;
    logic cand_v;
    found_s = 1'b0;
    win_s   = {TW{1'b0}};
    best_v  = 0;
    for (int w = 0; w < ways; w++) begin
      dist_v  = (w - int'(ptr_q) + ways) % ways;
      cand_v  = elig_s[w] & (~found_s | (dist_v < best_v));
      found_s = found_s | cand_v;
      best_v  = cand_v ? dist_v : best_v;
      win_s   = cand_v ? TW'(w) : win_s;
    end
  end

  // Route the winner's lane, flags and grant
  always_comb begin
    win_data_s = {DW{1'b0}};
    win_szl_s  = 1'b0;
    win_last_s = 1'b0;
    o_r        = {ways{1'b0}};
    for (int w = 0; w < ways; w++) begin
      win_data_s = (win_s == TW'(w)) ? i_d[w*DW +: DW] : win_data_s;
      win_szl_s  = (win_s == TW'(w)) ? i_szl[w] : win_szl_s;
      win_last_s = (win_s == TW'(w)) ? i_last[w] : win_last_s;
      o_r[w]     = accept_s & (win_s == TW'(w));
    end
  end

  assign dat_d = win_szl_s ? swap_bytes(win_data_s) : win_data_s;
  assign ptr_d = ptr_after(win_s);

`ifdef BASE_ENDIAN_ARB_LOCK_EN
  typedef enum logic {
    LK_IDLE   = 1'b0,
    LK_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e   lock_q;
  logic [TW-1:0] lock_id_q;

  // While a burst is open only its owner may be granted
  always_comb begin
    elig_s = {ways{1'b0}};
    for (int w = 0; w < ways; w++) begin
      if ((lock_q == LK_LOCKED) && (lock_id_q != TW'(w))) begin
        elig_s[w] = 1'b0;
      end else begin
        elig_s[w] = i_v[w];
      end
    end
  end

  // Burst lock state machine
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q    <= LK_IDLE;
      lock_id_q <= {TW{1'b0}};
    end else if (accept_s) begin
      case (lock_q)
        LK_IDLE: begin
          if (!win_last_s) begin
            lock_q    <= LK_LOCKED;
            lock_id_q <= win_s;
          end
        end
        LK_LOCKED: begin
          if (win_last_s) begin
            lock_q <= LK_IDLE;
          end
        end
        default: lock_q <= LK_IDLE;
      endcase
    end
  end

  assign ptr_adv_s = accept_s & win_last_s;
`else
  assign elig_s    = i_v;
  assign ptr_adv_s = accept_s;
`endif

  // Output stage and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_v_q  <= 1'b0;
      dat_q  <= {DW{1'b0}};
      tag_q  <= {TW{1'b0}};
      last_q <= 1'b0;
      ptr_q  <= {TW{1'b0}};
    end else begin
      if (accept_s) begin
        o_v_q  <= 1'b1;
        dat_q  <= dat_d;
        tag_q  <= win_s;
        last_q <= win_last_s;
      end else if (acc_en_s) begin
        o_v_q  <= 1'b0;
      end
      if (ptr_adv_s) begin
        ptr_q <= ptr_d;
      end
    end
  end

  assign o_v    = o_v_q;
  assign o_d    = dat_q;
  assign o_tag  = tag_q;
  assign o_last = last_q;

endmodule

// File: tb/tb_base_endian_arb.sv
// Directed bench for base_endian_arb with a behavioural reference model.
module tb_base_endian_arb;
  localparam int WAYS  = 2;
  localparam int BYTES = 8;
  localparam int DW    = 64;
`ifdef BASE_ENDIAN_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [0:WAYS-1]   i_v, o_r, i_szl, i_last;
  logic [0:WAYS*DW-1] i_d;
  logic              o_v, i_r, o_last;
  logic [0:DW-1]     o_d;
  logic [0:0]        o_tag;

  int n_checks = 0;
  int n_err    = 0;

  // reference model state
  bit            m_ov     = 1'b0;
  logic [0:DW-1] m_od     = '0;
  int            m_tag    = 0;
  bit            m_last   = 1'b0;
  int            m_ptr    = 0;
  bit            m_locked = 1'b0;
  int            m_lock_id = 0;

  base_endian_arb #(.ways(WAYS), .bytes(BYTES)) dut (
    .clk(clk), .reset(reset), .i_v(i_v), .o_r(o_r), .i_d(i_d),
    .i_szl(i_szl), .i_last(i_last), .o_v(o_v), .i_r(i_r),
    .o_d(o_d), .o_tag(o_tag), .o_last(o_last)
  );

  always #5 clk = ~clk;

  function automatic int pick();
    for (int i = 0; i < WAYS; i++) begin
      int w;
      w = (m_ptr + i) % WAYS;
      if (i_v[w] === 1'b1 && (!LOCK || !m_locked || w == m_lock_id)) return w;
    end
    return -1;
  endfunction

  function automatic logic [0:DW-1] lane(input int w);
    return i_d[w*DW +: DW];
  endfunction

  function automatic logic [0:DW-1] reverse(input logic [0:DW-1] d);
    logic [63:0] v, r;
    v = d;
    r = 64'h0;
    for (int k = 0; k < BYTES; k++) r = {r[55:0], v[8*k +: 8]};
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // reference model
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ov <= 1'b0; m_od <= '0; m_tag <= 0; m_last <= 1'b0;
      m_ptr <= 0; m_locked <= 1'b0; m_lock_id <= 0;
    end else if (!m_ov || i_r) begin
      if (pick() >= 0) begin
        m_od   <= i_szl[pick()] ? reverse(lane(pick())) : lane(pick());
        m_tag  <= pick();
        m_last <= i_last[pick()];
        m_ov   <= 1'b1;
        if (!LOCK || i_last[pick()]) m_ptr <= (pick() + 1) % WAYS;
        if (LOCK && !m_locked && !i_last[pick()]) begin
          m_locked  <= 1'b1;
          m_lock_id <= pick();
        end else if (LOCK && m_locked && i_last[pick()]) begin
          m_locked <= 1'b0;
        end
      end else begin
        m_ov <= 1'b0;
      end
    end
  end

  // cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    int p;
    logic [0:WAYS-1] er;
    p  = pick();
    er = '0;
    if ((!m_ov || i_r) && p >= 0) er[p] = 1'b1;
    check("o_r", 64'(o_r), 64'(er));
    check("o_v", 64'(o_v), 64'(m_ov));
    check("o_d", 64'(o_d), 64'(m_od));
    check("o_tag", 64'(o_tag), 64'(m_tag));
    check("o_last", 64'(o_last), 64'(m_last));
  end

  initial begin
    int beats;
    bit g0;
    int exp_tag[4];
`ifdef BASE_ENDIAN_ARB_LOCK_EN
    exp_tag = '{0, 0, 0, 1};
`else
    exp_tag = '{0, 1, 0, 1};
`endif
    reset = 1'b1; i_v = '0; i_szl = '0; i_last = '0; i_d = '0; i_r = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_o_v", 64'(o_v), 64'h0);
    check("rst_o_d", 64'(o_d), 64'h0);
    check("rst_o_tag", 64'(o_tag), 64'h0);
    step();
    reset = 1'b0;

    // swap and pass-through
    i_d[0:63] = 64'h0011223344556677; i_d[64:127] = 64'hFFEEDDCCBBAA9988;
    i_szl = 2'b10; i_last = 2'b11; i_v = 2'b10; i_r = 1'b1;
    @(negedge clk);
    check("swap_o_r", 64'(o_r), 64'h2);
    step();
    i_v = 2'b00;
    @(negedge clk);
    check("swap_o_d", 64'(o_d), 64'h7766554433221100);
    check("swap_o_tag", 64'(o_tag), 64'h0);
    check("swap_o_v", 64'(o_v), 64'h1);
    step();
    i_szl = 2'b00; i_v = 2'b10;
    step();
    i_v = 2'b00;
    @(negedge clk);
    check("pass_o_d", 64'(o_d), 64'h0011223344556677);

    // fairness
    step();
    do_reset();
    i_v = 2'b11; i_last = 2'b11; i_szl = 2'b01; i_r = 1'b1;
    i_d[0:63] = 64'h0102030405060708; i_d[64:127] = 64'h1112131415161718;
    for (int c = 0; c < 6; c++) begin
      step();
      @(negedge clk);
      check("fair_tag", 64'(o_tag), 64'(c % 2));
      check("fair_o_v", 64'(o_v), 64'h1);
    end

    // backpressure
    step();
    i_d[0:63] = 64'hAAAAAAAAAAAAAAAA; i_szl = 2'b00; i_v = 2'b10; i_r = 1'b1;
    step();
    i_r = 1'b0; i_v = 2'b01; i_d[64:127] = 64'h5555555555555555;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_o_r", 64'(o_r), 64'h0);
      check("bp_o_d", 64'(o_d), 64'hAAAAAAAAAAAAAAAA);
      check("bp_o_v", 64'(o_v), 64'h1);
      step();
    end
    i_r = 1'b1;
    @(negedge clk);
    check("bp_refill_o_r", 64'(o_r), 64'h1);
    step();
    i_v = 2'b00;
    @(negedge clk);
    check("bp_refill_o_d", 64'(o_d), 64'h5555555555555555);
    check("bp_refill_tag", 64'(o_tag), 64'h1);
    step();
    @(negedge clk);
    check("bp_drain_o_v", 64'(o_v), 64'h0);

    // burst
    step();
    do_reset();
    i_v = 2'b11; i_last = 2'b01; i_szl = 2'b00; i_r = 1'b1;
    beats = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      g0 = o_r[0];
      if (c >= 1 && c <= 4) check("burst_tag", 64'(o_tag), 64'(exp_tag[c-1]));
      step();
      if (g0) begin
        beats++;
        if (beats == 2) i_last[0] = 1'b1;
        if (beats == 3) i_v[0] = 1'b0;
      end
    end

    // reset in the middle of a burst
    i_v = 2'b10; i_last = 2'b00; i_r = 1'b1; i_d[0:63] = 64'h123456789ABCDEF0;
    step();
    i_r = 1'b0;
    step();
    reset = 1'b1; i_v = 2'b01; i_last = 2'b11;
    #1;
    check("mid_rst_o_v", 64'(o_v), 64'h0);
    check("mid_rst_o_tag", 64'(o_tag), 64'h0);
    check("mid_rst_o_d", 64'(o_d), 64'h0);
    i_r = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_o_r", 64'(o_r), 64'h1);
    step();
    i_v = 2'b00;
    @(negedge clk);
    check("post_rst_tag", 64'(o_tag), 64'h1);

    // idle with ready toggling
    step();
    i_v = 2'b10; i_last = 2'b11; i_r = 1'b1;
    step();
    i_v = 2'b00; i_r = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("idle_o_v", 64'(o_v), 64'h1);
      check("idle_o_r", 64'(o_r), 64'h0);
      step();
    end
    i_r = 1'b1;
    @(negedge clk);
    check("idle_drain_o_r", 64'(o_r), 64'h0);
    step();
    @(negedge clk);
    check("idle_fall_o_v", 64'(o_v), 64'h0);
    step();
    i_r = 1'b0;
    step();
    i_r = 1'b1;
    step();
    i_r = 1'b0;
    step();
    i_v = 2'b11; i_r = 1'b1;
    @(negedge clk);
    check("idle_ptr_o_r", 64'(o_r), 64'h1);
    step();
    i_v = 2'b00;
    @(negedge clk);
    check("idle_ptr_tag", 64'(o_tag), 64'h1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
